// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg : shared BCD limits, field width and validation helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  localparam int          BCD2_W    = 8;
  localparam logic [7:0]  SEC_MAX   = 8'h59;
  localparam logic [7:0]  MIN_MAX   = 8'h59;
  localparam logic [7:0]  HR_MAX_24 = 8'h23;

  // Both digits decimal and the field within its range (valid BCD orders like binary).
  function automatic logic bcd2_valid(input logic [BCD2_W-1:0] v,
                                      input logic [BCD2_W-1:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_counter.sv
// ---------------------------------------------------------------------------
// bcd2_counter : two-digit BCD counter wrapping at MAX, with synchronous load
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [BCD2_W-1:0] MAX = 8'h59
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [BCD2_W-1:0] load_val,
  output logic [BCD2_W-1:0] val,
  output logic              carry
);

  logic [BCD2_W-1:0] r_val;
  logic              w_at_max;

  assign w_at_max = (r_val == MAX);
  assign carry    = inc && w_at_max;
  assign val      = r_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
    end else if (load) begin
      r_val <= load_val;
    end else if (inc) begin
      if (w_at_max) begin
        r_val <= '0;
      end else if (r_val[3:0] == 4'd9) begin
        r_val <= {r_val[7:4] + 4'd1, 4'd0};
      end else begin
        r_val <= {r_val[7:4], r_val[3:0] + 4'd1};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rtc_time_counter.sv
// ---------------------------------------------------------------------------
// rtc_time_counter : prescaled BCD hh:mm:ss time-of-day with load and 12/24 h view
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rtc_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              mode_12h,
  input  logic              set_req,
  input  logic [BCD2_W-1:0] set_hh,
  input  logic [BCD2_W-1:0] set_mm,
  input  logic [BCD2_W-1:0] set_ss,
  output logic              set_ack,
  output logic              set_err,
  output logic [BCD2_W-1:0] hh,
  output logic [BCD2_W-1:0] mm,
  output logic [BCD2_W-1:0] ss,
  output logic              pm,
  output logic              sec_tick,
  output logic              day_roll
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] c_TC = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("rtc_time_counter: CLK_FREQ / TICK_HZ must be at least 2");
    end
  endgenerate

  logic [PW-1:0]     r_presc;
  logic              r_set_ack;
  logic              r_set_err;
  logic              r_sec_tick;
  logic              r_day_roll;
  logic              w_tc;
  logic              w_inc;
  logic              w_load_ok;
  logic              w_load;
  logic              w_ss_carry;
  logic              w_mm_carry;
  logic              w_hh_carry;
  logic [BCD2_W-1:0] w_hh24;
  logic [BCD2_W-1:0] w_mm;
  logic [BCD2_W-1:0] w_ss;

  assign w_tc      = run && (r_presc == c_TC);
  assign w_load_ok = bcd2_valid(set_hh, HR_MAX_24) &&
                     bcd2_valid(set_mm, MIN_MAX) &&
                     bcd2_valid(set_ss, SEC_MAX);
  assign w_load    = set_req && w_load_ok;
  // Any load request, valid or not, swallows a coincident terminal count.
  assign w_inc     = w_tc && !set_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (set_req) begin
      if (w_load_ok) begin
        r_presc <= '0;
      end
    end else if (run) begin
      if (w_tc) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_ack  <= 1'b0;
      r_set_err  <= 1'b0;
      r_sec_tick <= 1'b0;
      r_day_roll <= 1'b0;
    end else begin
      r_set_ack  <= w_load;
      r_set_err  <= set_req && !w_load_ok;
      r_sec_tick <= w_inc;
      r_day_roll <= w_hh_carry;
    end
  end

  bcd2_counter #(.MAX(SEC_MAX)) u_ss (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_inc),
    .load     (w_load),
    .load_val (set_ss),
    .val      (w_ss),
    .carry    (w_ss_carry)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_mm (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_ss_carry),
    .load     (w_load),
    .load_val (set_mm),
    .val      (w_mm),
    .carry    (w_mm_carry)
  );

  bcd2_counter #(.MAX(HR_MAX_24)) u_hh (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_mm_carry),
    .load     (w_load),
    .load_val (set_hh),
    .val      (w_hh24),
    .carry    (w_hh_carry)
  );

  // 12 h view: BCD subtract of 12 borrows from the tens digit when units < 2.
  always_comb begin
    hh = w_hh24;
    pm = 1'b0;
    if (mode_12h) begin
      if (w_hh24 == 8'h00) begin
        hh = 8'h12;
      end else if (w_hh24 == 8'h12) begin
        pm = 1'b1;
      end else if (w_hh24 > 8'h12) begin
        pm = 1'b1;
        if (w_hh24[3:0] >= 4'd2) begin
          hh = {w_hh24[7:4] - 4'd1, w_hh24[3:0] - 4'd2};
        end else begin
          hh = {w_hh24[7:4] - 4'd2, w_hh24[3:0] + 4'd8};
        end
      end
    end
  end

  assign mm       = w_mm;
  assign ss       = w_ss;
  assign set_ack  = r_set_ack;
  assign set_err  = r_set_err;
  assign sec_tick = r_sec_tick;
  assign day_roll = r_day_roll;

endmodule

`default_nettype wire

// File: doc/rtc_time_counter.md
# rtc_time_counter

Parametrised time-of-day counter for the digital clock: divides the board clock down to a 1 Hz (configurable) tick and advances a BCD hh:mm:ss time. It supports run/hold, synchronous time load with validation, and a 12/24-hour display mode. It sits between the crystal clock input and the seven-segment/LED display driver, and replaces the fixed-modulus LED counter.

## Interface
- `CLK_FREQ`, 50_000_000: input clock frequency in Hz.
- `TICK_HZ`, 1: time-advance rate in Hz. `DIV = CLK_FREQ / TICK_HZ`; the design requires `DIV >= 2` (elaboration error otherwise).
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 = time advances on tick; 0 = prescaler and time hold.
- `mode_12h`  in  1  display format select; 0 = 24 h, 1 = 12 h.
- `set_req`  in  1  single-cycle load request.
- `set_hh`, `set_mm`, `set_ss`  in  8 each  load value, two BCD digits each, in 24 h format.
- `set_ack`  out  1  one-cycle pulse: load accepted.
- `set_err`  out  1  one-cycle pulse: load rejected.
- `hh`, `mm`, `ss`  out  8 each  current time as two BCD digits each; `hh` is formatted per `mode_12h`.
- `pm`  out  1  PM flag; valid in 12 h mode, forced to 0 in 24 h mode.
- `sec_tick`  out  1  one-cycle pulse in the cycle the seconds field changes.
- `day_roll`  out  1  one-cycle pulse in the cycle the time wraps from 23:59:59 to 00:00:00.

## Operation
- Reset (async assert, sync deassert by system) forces:
  - prescaler = 0
  - internal time = 00:00:00
  - `set_ack`, `set_err`, `sec_tick`, `day_roll` = 0
  - `hh`/`mm`/`ss` = 00/00/00 in 24 h mode; 12/00/00 with `pm` = 0 in 12 h mode.
- Prescaler behaviour with `run`=1:
  - Counts 0..DIV-1.
  - On the edge where it equals DIV-1, it returns to 0 and the time increments by one second.
- With `run`=0 the prescaler and time hold. Resuming continues from the held prescaler value, with no extra tick.
- Increment rules:
  - Each field is two BCD digits; the units digit wraps 9→0 and carries into tens.
  - ss wraps 59→00 and carries to mm; mm wraps 59→00 and carries to hh; hh wraps 23→00.
  - All carries ripple within the same edge.
- Internal hours are always 24 h. Display formatting is combinational from the registers:
  - 24 h mode: `hh` shows the internal value directly.
  - 12 h mode, internal 00: `hh`=12, `pm`=0.
  - Internal 01–11: `hh` unchanged, `pm`=0.
  - Internal 12: `hh`=12, `pm`=1.
  - Internal 13–23: `hh` = internal − 12 in BCD, `pm`=1.
- Load validation: valid iff every BCD digit ≤ 9, `set_ss` ≤ 0x59, `set_mm` ≤ 0x59, `set_hh` ≤ 0x23.
  - Valid load: the time is loaded on the next edge, the prescaler clears to 0, and `set_ack`=1 for that one cycle.
  - Invalid load: the time and prescaler are unchanged, and `set_err`=1 for one cycle.
- A load is accepted regardless of `run`.
- Simultaneous `set_req` and prescaler terminal count: the load wins, the tick is discarded, and `sec_tick`/`day_roll` stay 0.
- `set_req` held high for several cycles is treated as one request per cycle. Each cycle is re-validated and re-acked, and the prescaler stays 0.
- Reset asserted mid-load or mid-tick overrides everything; no pulse is emitted.

## Timing
- `sec_tick` and `day_roll` are registered. They are high during the first cycle after the edge on which the new time becomes visible, and coincide with the updated `ss`.
- Tick period is exactly DIV clk cycles while `run`=1 with no load. After a valid load, the first tick occurs DIV cycles after the load edge.
- `set_ack`/`set_err` are registered. They are high in the cycle after the `set_req` cycle, simultaneous with the loaded time.
- `hh`/`mm`/`ss`/`pm` follow `mode_12h` combinationally within the same cycle; there is no latency on a mode change.

## Structure
- Shared package `clock_pkg` holds:
  - constants `SEC_MAX` = 8'h59, `MIN_MAX` = 8'h59, `HR_MAX_24` = 8'h23
  - BCD field width `BCD2_W` = 8
  - function `bcd2_valid`.
- Sub-module `bcd2_counter`: two-digit BCD counter with `inc`, `load`, `load_val`, parameter `MAX`, and outputs `val` and `carry`. It is instantiated three times (ss, mm, hh).
- Prescaler width is `$clog2(DIV)`.
- The 12 h conversion is a local combinational block in the top module.

## Test plan
- Reset and count, with `CLK_FREQ`=10, `TICK_HZ`=1 (DIV=10), `run`=1:
  - Release reset, wait 10 cycles → `ss`=0x01 with `sec_tick` high for exactly one cycle.
  - After 600 cycles → `mm`=0x01, `ss`=0x00.
- Day wrap: load 0x23/0x59/0x58, run 20 cycles → second tick gives 00:00:00 with `day_roll`=1 for one cycle, coinciding with `sec_tick`.
- Validation:
  - `set_ss`=0x60 → `set_err`=1, time unchanged.
  - `set_hh`=0x1A → `set_err`.
  - `set_hh`=0x23, `set_mm`=0x00, `set_ss`=0x00 → `set_ack`, time = 23:00:00.
- Collision and hold:
  - Assert `set_req` on the terminal-count cycle → loaded value shown, no `sec_tick`, next tick exactly 10 cycles later.
  - `run`=0 for 50 cycles → time frozen.
- 12 h mode: internal 00:xx shows `hh`=0x12, `pm`=0; 13:05:00 shows `hh`=0x01, `pm`=1; toggling `mode_12h` changes `hh` in the same cycle.
- Async reset: assert `rst` between clock edges mid-count → all outputs return to reset values before the next edge.
